idma_channel_arbiter: RTL and testbench
=======================================

# idma_channel_arbiter

Shares one iDMA backend between `NumChannels` independent frontends (e.g. several 64-bit register frontends). Grants backend burst requests round-robin and keeps the grant stable under backpressure. Records the issuing channel of every accepted transfer in an in-order tracking FIFO, so that each backend completion is returned to the channel that issued it. Sits between the frontends' `burst_req/valid/ready/trans_complete` signals and the single backend port.

## Interface
Parameters:
- `NumChannels`, 4: number of frontend channels, 2..16.
- `MaxInflight`, 8: tracking FIFO depth (transfers accepted by the backend but not completed); power of two, 2..64.
- `burst_req_t`, logic: backend burst request type, passed through unmodified.

Ports:
- `clk_i` in 1: clock; the block uses a single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `ch_req_i` in `NumChannels` x `burst_req_t`: per-channel burst request.
- `ch_valid_i` in `NumChannels`: per-channel request valid.
- `ch_ready_o` out `NumChannels`: per-channel request accepted.
- `ch_done_o` out `NumChannels`: one-cycle pulse per completed transfer of that channel.
- `ch_busy_o` out `NumChannels`: channel has at least one transfer in flight.
- `burst_req_o` out `burst_req_t`: request to the backend.
- `valid_o` out 1: backend request valid.
- `ready_i` in 1: backend accepts the request.
- `trans_complete_i` in 1: backend retired its oldest transfer.
- `idle_o` out 1: FIFO empty and `valid_o` low.
- `err_o` out 1: sticky; a completion arrived while the FIFO was empty.

## Operation
- **Arbiter:** round-robin over `ch_valid_i`, starting from the `rr_ptr` register. The winner is the first valid channel at index ≥ `rr_ptr`, wrapping modulo `NumChannels`.
- **Lock:**
  - When `valid_o && !ready_i`, register `locked=1` and `lock_idx=grant`.
  - While locked, the grant stays `lock_idx` regardless of other valids. This keeps `burst_req_o` stable per the valid/ready rule.
  - Frontends must hold `ch_valid_i`/`ch_req_i` until `ch_ready_o`. A violation is a frontend error and is not handled.
- **Issue:**
  - `valid_o = |ch_valid_i && !fifo_full`.
  - `burst_req_o = ch_req_i[grant]`; it is `'0` when `valid_o` is low.
  - `ch_ready_o[grant] = ready_i && valid_o`; all other `ch_ready_o` bits are 0.
  - `issue = valid_o && ready_i`.
- **On issue:**
  - Push `grant` into the tracking FIFO.
  - `rr_ptr <= (grant+1) mod NumChannels`.
  - `locked <= 0`.
  - `inflight_cnt[grant]++`.
- **Completion:**
  - On `trans_complete_i` with the FIFO non-empty: pop the head index `h`, `inflight_cnt[h]--`, and register `ch_done_o[h]=1` for the next cycle.
  - On `trans_complete_i` with the FIFO empty: set `err_o`; no other state changes.
- **FIFO full:**
  - `valid_o` is forced low, even if a pop occurs in the same cycle. This avoids a combinational path from `trans_complete_i` to `valid_o`.
  - Full is only reached with `locked=0`, because a push clears the lock. `valid_o` therefore never drops while a request is pending un-accepted.
- **Simultaneous push and pop** (not full): both take effect and the occupancy is unchanged. If push and pop hit the same channel, `inflight_cnt` for that channel is unchanged.
- **Flags:** `ch_busy_o[i] = (inflight_cnt[i] != 0)`. Counters are `$clog2(MaxInflight+1)` bits wide and cannot overflow, because the FIFO bounds them.
- **Reset:** `rr_ptr=0`, `locked=0`, FIFO empty, all counters 0, `ch_done_o=0`, `err_o=0`.
  - Transfers in flight in the backend at reset are forgotten; their later completions set `err_o`.
  - Integration must reset the backend together with this block.

## Timing
- Request path (`ch_valid_i`/`ch_req_i` to `valid_o`/`burst_req_o`) is combinational: zero-cycle latency.
- Backpressure path (`ready_i` to `ch_ready_o`) is combinational.
- `ch_done_o` pulses exactly 1 cycle after the accepting `trans_complete_i` edge cycle.
- `ch_busy_o` and `idle_o` reflect registered state: updated the cycle after issue or completion.
- Back-to-back issues (one per cycle) are supported until the FIFO is full.
- Throughput is one issue and one completion per cycle.
- Output values during and after reset:
  - Driven to 0: `valid_o`, `ch_ready_o`, `ch_done_o`, `ch_busy_o`, `err_o`.
  - `idle_o` is 1.

## Test plan
- **Round-robin:** `NumChannels=4`, all `ch_valid_i=4'b1111`, `ready_i=1` -> grants in order 0,1,2,3,0; `rr_ptr` wraps; one issue per cycle.
- **Lock under backpressure:** channel 2 valid with `ready_i=0` for 5 cycles, channel 0 asserts valid at cycle 2 -> `burst_req_o` remains `ch_req_i[2]` for all 5 cycles; channel 2 is accepted when `ready_i=1`; channel 0 is granted next.
- **Completion routing:** issue ch1, ch3, ch1, then 3 `trans_complete_i` pulses -> `ch_done_o` = `4'b0010`, `4'b1000`, `4'b0010`, each 1 cycle after its pulse; `ch_busy_o[1]` clears only after the third.
- **FIFO full:** `MaxInflight=8`, issue 8 without completion -> `valid_o=0` while channels are still valid. A complete in the same cycle as a pending request -> no issue that cycle; issue on the next cycle.
- **Spurious completion:** `trans_complete_i` while idle -> `err_o=1` and stays 1; `ch_done_o` stays 0; counters unchanged.
- **Reset mid-operation:** 3 transfers in flight, assert `rst_i` for 1 cycle -> next cycle `idle_o=1`, `ch_busy_o=0`, `rr_ptr=0`; a subsequent `trans_complete_i` sets `err_o`.

Source files
------------

// File: rtl/idma_channel_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between several frontends.
// Tracks the issuing channel of each accepted transfer and routes completions back to it.
module idma_channel_arbiter #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned MaxInflight = 8,
    parameter type         burst_req_t = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  burst_req_t             ch_req_i [NumChannels],
    input  logic [NumChannels-1:0] ch_valid_i,
    output logic [NumChannels-1:0] ch_ready_o,
    output logic [NumChannels-1:0] ch_done_o,
    output logic [NumChannels-1:0] ch_busy_o,
    output burst_req_t             burst_req_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    input  logic                   trans_complete_i,
    output logic                   idle_o,
    output logic                   err_o
);

    localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned PtrW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
    localparam int unsigned CntW = $clog2(MaxInflight + 1);

    logic [IdxW-1:0]        rr_ptr;
    logic                   locked;
    logic [IdxW-1:0]        lock_idx;
    logic [IdxW-1:0]        fifo_mem [MaxInflight];
    logic [PtrW-1:0]        wr_ptr;
    logic [PtrW-1:0]        rd_ptr;
    logic [CntW-1:0]        fill_cnt;
    logic [CntW-1:0]        fill_nxt;
    logic [CntW-1:0]        inflight_cnt [NumChannels];
    logic [CntW-1:0]        cnt_nxt [NumChannels];
    logic [NumChannels-1:0] done_q;
    logic [NumChannels-1:0] done_d;
    logic                   err_q;

    logic [IdxW-1:0]        grant_rr;
    logic [IdxW-1:0]        grant;
    logic [IdxW-1:0]        rr_nxt;
    logic [IdxW-1:0]        head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   issue;
    logic                   pop;

    // Round-robin search: first valid channel at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_rr = rr_ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NumChannels) begin
                idx = idx - NumChannels;
            end
            if (!found && ch_valid_i[IdxW'(idx)]) begin
                found    = 1'b1;
                grant_rr = IdxW'(idx);
            end
        end
    end

    assign grant      = locked ? lock_idx : grant_rr;
    assign rr_nxt     = (grant == IdxW'(NumChannels - 1)) ? '0 : grant + IdxW'(1);
    assign fifo_full  = (fill_cnt == CntW'(MaxInflight));
    assign fifo_empty = (fill_cnt == '0);
    assign head       = fifo_mem[rd_ptr];

    // Full is judged on registered occupancy only, so a same-cycle pop cannot reach valid_o.
    assign valid_o = (|ch_valid_i) && !fifo_full && !rst_i;
    assign issue   = valid_o && ready_i;
    assign pop     = trans_complete_i && !fifo_empty;

    assign burst_req_o = valid_o ? ch_req_i[grant] : '0;
    assign idle_o      = fifo_empty && !valid_o;
    assign ch_done_o   = done_q;
    assign err_o       = err_q;

    always_comb begin
        ch_ready_o = '0;
        if (issue) begin
            ch_ready_o[grant] = 1'b1;
        end
    end

    always_comb begin
        done_d = '0;
        if (pop) begin
            done_d[head] = 1'b1;
        end
    end

    always_comb begin
        fill_nxt = fill_cnt;
        case ({issue, pop})
            2'b10:   fill_nxt = fill_cnt + CntW'(1);
            2'b01:   fill_nxt = fill_cnt - CntW'(1);
            default: fill_nxt = fill_cnt;
        endcase
    end

    // Per-channel in-flight counters; a push and pop on the same channel cancel.
    always_comb begin
        logic inc;
        logic dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            inc          = issue && (grant == IdxW'(i));
            dec          = pop && (head == IdxW'(i));
            cnt_nxt[i]   = inflight_cnt[i];
            if (inc && !dec) begin
                cnt_nxt[i] = inflight_cnt[i] + CntW'(1);
            end else if (dec && !inc) begin
                cnt_nxt[i] = inflight_cnt[i] - CntW'(1);
            end
            ch_busy_o[i] = (inflight_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NumChannels; i++) begin
                inflight_cnt[i] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr <= rr_nxt;
                locked <= 1'b0;
            end else if (valid_o) begin
                locked   <= 1'b1;
                lock_idx <= grant;
            end
            if (issue) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            fill_cnt <= fill_nxt;
            done_q   <= done_d;
            if (trans_complete_i && fifo_empty) begin
                err_q <= 1'b1;
            end
            for (int unsigned i = 0; i < NumChannels; i++) begin
                inflight_cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Tracking storage holds only channel indices; contents are don't-care when empty.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_idma_channel_arbiter.sv
// Directed and randomized bench for idma_channel_arbiter against a queue-based reference model.
module tb_idma_channel_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned MI = 8;
    typedef logic [15:0] req_t;

    logic         clk = 1'b0;
    logic         rst;
    req_t         reqs [N];
    req_t         nreq [N];
    logic [N-1:0] vld;
    logic [N-1:0] ch_ready;
    logic [N-1:0] ch_done;
    logic [N-1:0] ch_busy;
    req_t         burst_req;
    logic         valid;
    logic         ready;
    logic         tc;
    logic         idle;
    logic         err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int           m_rr;
    bit           m_locked;
    int           m_lock_idx;
    int           m_q[$];
    int           m_cnt [N];
    logic [N-1:0] m_done;
    bit           m_err;
    logic [N-1:0] acc_mask;

    idma_channel_arbiter #(
        .NumChannels(N),
        .MaxInflight(MI),
        .burst_req_t(req_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ch_req_i        (reqs),
        .ch_valid_i      (vld),
        .ch_ready_o      (ch_ready),
        .ch_done_o       (ch_done),
        .ch_busy_o       (ch_busy),
        .burst_req_o     (burst_req),
        .valid_o         (valid),
        .ready_i         (ready),
        .trans_complete_i(tc),
        .idle_o          (idle),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_rr       = 0;
        m_locked   = 0;
        m_lock_idx = 0;
        m_q.delete();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_done = '0;
        m_err  = 0;
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance the model.
    task automatic step(input logic [N-1:0] v, input logic rdy, input logic c, input logic r);
        int           g;
        int           h;
        bit           ev;
        logic [N-1:0] er;
        logic [N-1:0] eb;
        logic [N-1:0] nd;
        req_t         eq;
        @(negedge clk);
        for (int i = 0; i < N; i++) reqs[i] = nreq[i];
        vld = v; ready = rdy; tc = c; rst = r;
        #1;
        ev = (v != '0) && (m_q.size() < MI) && !r;
        g  = -1;
        if (m_locked) g = m_lock_idx;
        else for (int k = 0; k < N; k++) if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
        eq = ev ? nreq[g] : '0;
        er = '0;
        if (ev && rdy) er[g] = 1'b1;
        for (int i = 0; i < N; i++) eb[i] = (m_cnt[i] != 0);
        chk("valid_o", 32'(valid), 32'(ev));
        chk("burst_req_o", 32'(burst_req), 32'(eq));
        chk("ch_ready_o", 32'(ch_ready), 32'(er));
        chk("ch_busy_o", 32'(ch_busy), 32'(eb));
        chk("ch_done_o", 32'(ch_done), 32'(m_done));
        chk("idle_o", 32'(idle), 32'((m_q.size() == 0) && !ev));
        chk("err_o", 32'(err), 32'(m_err));
        acc_mask = er;
        if (r) begin
            reset_model();
        end else begin
            nd = '0;
            if (c) begin
                if (m_q.size() == 0) m_err = 1;
                else begin
                    h = m_q.pop_front();
                    m_cnt[h]--;
                    nd[h] = 1'b1;
                end
            end
            if (ev && rdy) begin
                m_q.push_back(g);
                m_cnt[g]++;
                m_rr     = (g + 1) % N;
                m_locked = 0;
            end else if (ev) begin
                m_locked   = 1;
                m_lock_idx = g;
            end
            m_done = nd;
        end
    endtask

    initial begin
        logic [N-1:0] hold;
        for (int i = 0; i < N; i++) begin
            nreq[i] = req_t'(16'h1000 + i);
            reqs[i] = nreq[i];
        end
        vld = '0; ready = 1'b0; tc = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        reset_model();
        step('0, 1'b0, 1'b0, 1'b0);
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_busy", 32'(ch_busy), 32'd0);

        // Round-robin with all channels requesting
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("rr_g0", 32'(ch_ready), 32'b0001);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("rr_g1", 32'(ch_ready), 32'b0010);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("rr_g2", 32'(ch_ready), 32'b0100);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("rr_g3", 32'(ch_ready), 32'b1000);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("rr_wrap", 32'(ch_ready), 32'b0001);
        repeat (5) step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("rr_drained_idle", 32'(idle), 32'd1);

        // Lock under backpressure: channel 0 joins while channel 2 waits
        step(4'b0100, 1'b0, 1'b0, 1'b0); chk("lock_req_c1", 32'(burst_req), 32'h1002);
        for (int c = 2; c <= 5; c++) begin
            step(4'b0101, 1'b0, 1'b0, 1'b0);
            chk("lock_req_held", 32'(burst_req), 32'h1002);
        end
        step(4'b0101, 1'b1, 1'b0, 1'b0); chk("lock_accept2", 32'(ch_ready), 32'b0100);
        step(4'b0001, 1'b1, 1'b0, 1'b0); chk("lock_next0", 32'(ch_ready), 32'b0001);
        repeat (2) step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);

        // Completion routing
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1, 1'b0); chk("route_busy", 32'(ch_busy), 32'b1010);
        step('0, 1'b0, 1'b1, 1'b0); chk("route_done1", 32'(ch_done), 32'b0010);
        step('0, 1'b0, 1'b1, 1'b0); chk("route_done3", 32'(ch_done), 32'b1000);
        chk("route_busy1_held", 32'(ch_busy[1]), 32'd1);
        step('0, 1'b0, 1'b0, 1'b0); chk("route_done1b", 32'(ch_done), 32'b0010);
        chk("route_busy_clear", 32'(ch_busy), 32'd0);

        // FIFO full
        repeat (MI) step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("full_valid_low", 32'(valid), 32'd0);
        step(4'b1111, 1'b1, 1'b1, 1'b0); chk("full_pop_no_issue", 32'(ch_ready), 32'd0);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("full_issue_after", 32'(valid), 32'd1);
        repeat (MI) step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0); chk("full_drained", 32'(idle), 32'd1);

        // Spurious completion
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0); chk("spur_err", 32'(err), 32'd1);
        chk("spur_no_done", 32'(ch_done), 32'd0);
        step('0, 1'b0, 1'b0, 1'b0); chk("spur_err_sticky", 32'(err), 32'd1);

        // Reset with transfers in flight
        step('0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0); chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_busy", 32'(ch_busy), 32'd0);
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0); chk("rst_late_err", 32'(err), 32'd1);
        step(4'b1111, 1'b1, 1'b0, 1'b0); chk("rst_rr_zero", 32'(ch_ready), 32'b0001);
        step('0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic obeying the hold-until-ready rule
        hold = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && ($urandom_range(1) == 1)) begin
                    hold[i] = 1'b1;
                    nreq[i] = req_t'($urandom);
                end
            end
            step(hold, ($urandom_range(3) != 0), ($urandom_range(1) == 1),
                 ($urandom_range(249) == 0));
            hold = hold & ~acc_mask;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
